// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: write/increment strobes, two tri-state read ports, sticky error.
// dbg_flip_parity exists only when REGISTER_BANK_PARITY_EN is defined.
interface register_bank_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              inc_en;
   logic [ADDR_W-1:0] inc_addr;
   logic              rd_a_en;
   logic [ADDR_W-1:0] rd_a_addr;
   wire  [WIDTH-1:0]  rd_a_data;
   logic              rd_a_valid;
   logic              rd_b_en;
   logic [ADDR_W-1:0] rd_b_addr;
   wire  [WIDTH-1:0]  rd_b_data;
   logic              rd_b_valid;
   logic              err;
`ifdef REGISTER_BANK_PARITY_EN
   logic              dbg_flip_parity;
`endif

   modport master (
      output wr_en, wr_addr, wr_data, inc_en, inc_addr,
      output rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
`ifdef REGISTER_BANK_PARITY_EN
      output dbg_flip_parity,
`endif
      input  rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, inc_en, inc_addr,
      input  rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
`ifdef REGISTER_BANK_PARITY_EN
      input  dbg_flip_parity,
`endif
      output rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, err
   );
endinterface

// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank: one write port, one increment port, two registered tri-state read ports.
// Optional even-parity protection per register with REGISTER_BANK_PARITY_EN.
module register_bank #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int ZERO_REG = 0
) (
   input  logic           clk,
   input  logic           rst,
   register_bank_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);
`ifdef REGISTER_BANK_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif

   typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} rd_state_t;

   logic [SW-1:0]     mem_reg [DEPTH];
   logic [DEPTH-1:0]  wr_hit;
   logic [DEPTH-1:0]  inc_hit;
   logic              wr_ok, inc_ok, wr_oor, inc_oor;
   logic [WIDTH-1:0]  inc_cur, inc_sum;
   logic [SW-1:0]     wr_word, inc_word;
   logic [1:0]        rd_en;
   logic [ADDR_W-1:0] rd_addr [2];
   rd_state_t         state_reg [2];
   rd_state_t         state_next [2];
   logic [WIDTH-1:0]  data_reg [2];
   logic [WIDTH-1:0]  data_next [2];
   logic              err_reg, err_next;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign wr_oor  = bus.wr_en  && !in_range(bus.wr_addr);
   assign inc_oor = bus.inc_en && !in_range(bus.inc_addr);
   assign wr_ok   = bus.wr_en  && in_range(bus.wr_addr)  && !is_zero(bus.wr_addr);
   assign inc_ok  = bus.inc_en && in_range(bus.inc_addr) && !is_zero(bus.inc_addr);
   assign inc_cur = in_range(bus.inc_addr) ? mem_reg[bus.inc_addr][WIDTH-1:0] : '0;
   assign inc_sum = inc_cur + WIDTH'(1);

   // Words are formed exactly as they will be stored, so bypassed reads see the same parity.
`ifdef REGISTER_BANK_PARITY_EN
   assign wr_word  = {(^bus.wr_data) ^ bus.dbg_flip_parity, bus.wr_data};
   assign inc_word = {^inc_sum, inc_sum};
`else
   assign wr_word  = bus.wr_data;
   assign inc_word = inc_sum;
`endif

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign wr_hit[gi]  = wr_ok  && (bus.wr_addr  == ADDR_W'(gi));
      assign inc_hit[gi] = inc_ok && (bus.inc_addr == ADDR_W'(gi));
   end

   // Write has priority over increment on the same register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i])       mem_reg[i] <= wr_word;
            else if (inc_hit[i]) mem_reg[i] <= inc_word;
         end
      end
   end

   always_comb begin
      rd_en      = {bus.rd_b_en, bus.rd_a_en};
      rd_addr[0] = bus.rd_a_addr;
      rd_addr[1] = bus.rd_b_addr;
   end

   always_comb begin
      logic [SW-1:0] sel;
      sel      = '0;
      err_next = err_reg | wr_oor | inc_oor;
      for (int p = 0; p < 2; p++) begin
         state_next[p] = rd_en[p] ? DRIVE : IDLE;
         data_next[p]  = data_reg[p];
         sel           = '0;
         if (rd_en[p]) begin
            if (!in_range(rd_addr[p])) begin
               err_next = 1'b1;
            end else if (!is_zero(rd_addr[p])) begin
               if (wr_ok && (bus.wr_addr == rd_addr[p]))        sel = wr_word;
               else if (inc_ok && (bus.inc_addr == rd_addr[p])) sel = inc_word;
               else                                             sel = mem_reg[rd_addr[p]];
            end
            data_next[p] = sel[WIDTH-1:0];
`ifdef REGISTER_BANK_PARITY_EN
            if (^sel) err_next = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            state_reg[p] <= IDLE;
            data_reg[p]  <= '0;
         end
         err_reg <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            state_reg[p] <= state_next[p];
            data_reg[p]  <= data_next[p];
         end
         err_reg <= err_next;
      end
   end

   assign bus.rd_a_valid = (state_reg[0] == DRIVE);
   assign bus.rd_b_valid = (state_reg[1] == DRIVE);
   assign bus.rd_a_data  = (state_reg[0] == DRIVE) ? data_reg[0] : 'z;
   assign bus.rd_b_data  = (state_reg[1] == DRIVE) ? data_reg[1] : 'z;
   assign bus.err        = err_reg;
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised multi-register bank; successor to the single tri-state register.
- DEPTH registers of WIDTH bits each.
- One synchronous write port and one increment port.
- Two independent registered read ports that drive a shared bus: high-Z when idle.
- Used as the CPU-side general register set and PC/pointer store on the internal tri-state data buses.

Parameters:
- WIDTH, 16, data width of each register and each bus.
- DEPTH, 8, number of registers (2..256, need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden).
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes/increments.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- inc_en  in  1  increment strobe
- inc_addr  in  ADDR_W  register to increment by 1
- rd_a_en  in  1  read request, port A
- rd_a_addr  in  ADDR_W  read address, port A
- rd_a_data  out  WIDTH  tri-state bus, port A
- rd_a_valid  out  1  port A driving bus this cycle
- rd_b_en, rd_b_addr, rd_b_data, rd_b_valid: same as port A, for port B
- err  out  1  sticky error flag

Behaviour:
- Reset (async, immediate):
  - all registers = 0
  - rd_a_valid = rd_b_valid = 0
  - rd_a_data/rd_b_data = all Z
  - err = 0
  - reset mid-operation discards any pending read and pending write.
- Write:
  - on the clk edge with wr_en=1, reg[wr_addr] <= wr_data.
- Increment:
  - on the clk edge with inc_en=1, reg[inc_addr] <= reg[inc_addr]+1, modulo 2^WIDTH.
  - all-ones wraps to 0; no carry out.
- Write and increment on the same address in the same cycle:
  - the write wins and the increment is dropped.
  - on different addresses, both take effect.
- Read latency is 1 cycle:
  - rd_x_en sampled at edge N.
  - at edge N, rd_x_data register <= selected value, and rd_x_valid <= 1 for one cycle.
  - during cycle N+1, the bus is driven with that value.
  - when rd_x_valid=0, rd_x_data is all Z.
  - back-to-back reads are allowed, one per cycle per port; valid stays high continuously.
- Read/write collision on the same address, same edge (write-first bypass):
  - the read returns wr_data.
  - if only an increment hits the read address, the read returns the incremented value.
- Both ports may read the same address in the same cycle; both return the same data.
- ZERO_REG=1:
  - reads of address 0 return 0.
  - writes and increments to address 0 are ignored, including bypass (the read still returns 0).
- Out-of-range address (addr >= DEPTH):
  - writes and increments are ignored.
  - a read returns 0 with valid=1.
  - err <= 1 on that edge; err is sticky until rst.
- No other state machine: each read port is a 2-state IDLE/DRIVE flop.
  - IDLE -> DRIVE on rd_en.
  - DRIVE -> IDLE on !rd_en.
  - DRIVE -> DRIVE on rd_en.

Optional Feature:
- Macro: REGISTER_BANK_PARITY_EN.
- Defined:
  - each register stores one extra even-parity bit, computed from write data and recomputed on increment.
  - each read recomputes parity; on mismatch, err <= 1 (sticky) in the cycle valid rises.
  - data is still returned unchanged.
  - a hidden debug-only input dbg_flip_parity (1 bit) inverts the stored parity on the next write, for test.
- Not defined:
  - no parity storage, no dbg_flip_parity port.
  - err is set only by out-of-range accesses.

Test Plan:
- Reset release; write 0xBEEF to addr 3; next cycle read A addr 3 -> cycle after, rd_a_valid=1, rd_a_data=0xBEEF; port B bus = Z.
- Same edge: wr_en addr 5 data 0x1234 and rd_b_en addr 5 -> rd_b_data=0x1234 next cycle (bypass); then write 0x0001 and inc both to addr 5 -> reg5=0x0001.
- Write 0xFFFF to addr 2, inc_en addr 2 -> read returns 0x0000 (wrap); inc again -> 0x0001.
- ZERO_REG=1: write 0xAAAA to addr 0, read A and B addr 0 in the same cycle -> both return 0x0000; err=0.
- DEPTH=6: read addr 7 -> data 0x0000, valid=1, err=1; write addr 7 does not alter regs 0..5; err stays 1 until rst.
- Assert rst while rd_a_valid=1 -> bus goes Z and valid goes 0 immediately; all regs read 0 afterwards. With REGISTER_BANK_PARITY_EN, use dbg_flip_parity on a write, then read -> err=1 with correct data returned.
